gate_truth_checker: RTL
=======================

// Module: gate_truth_checker
// PURPOSE
//  Self-checking stimulus/response engine for the basic gate library.
//  - Drives every input combination into a combinational gate-under-test (GUT).
//  - Samples the GUT output and compares it against a parameterised truth table.
//  - Reports error count, first failing vector and pass/done.
//  - Used on-chip or in benches to qualify and2/or2/xor2-class cells without a hand-written sequence.
// PARAMETERS
//  N_IN    2        number of GUT inputs (1..6); vectors 0..2**N_IN-1
//  TRUTH   4'b1000  expected output per vector, bit v = expected C for input v (default = AND2)
//  SETTLE  2        cycles each vector is held before sampling (>=1)
//  ERR_W   8        width of error counter (saturating)
// PORTS
//  clk            in   1          rising-edge clock
//  rst            in   1          asynchronous, active-high reset
//  start          in   1          begin a sweep; accepted only when not busy
//  gut_in         out  N_IN       stimulus to GUT; bit 0 = input A, bit 1 = input B, ...
//  gut_out        in   1          GUT output C
//  busy           out  1          sweep in progress
//  done           out  1          sweep complete; held until next accepted start or reset
//  pass           out  1          done && err_cnt==0
//  err_cnt        out  ERR_W      mismatches in current/last sweep, saturates at 2**ERR_W-1
//  fail_valid     out  1          at least one mismatch recorded
//  fail_vec       out  N_IN       vector index of first mismatch
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; outputs gut_in, busy, done, pass, err_cnt, fail_valid, fail_vec all 0.
//  - States:
//    - IDLE: wait for start.
//    - HOLD: gut_in=v; cycle counter runs SETTLE cycles.
//    - CHECK: single cycle; compare gut_out vs TRUTH[v].
//    - DONE: results held.
//  - Start acceptance: start high at an edge in IDLE or DONE -> HOLD, v=0, gut_in=0, busy=1, done=0,
//    err_cnt=0, fail_valid=0, fail_vec=0. start while busy is ignored; no queuing.
//  - HOLD -> CHECK after SETTLE cycles.
//  - CHECK -> HOLD with v=v+1 (gut_in updates at the same edge), or -> DONE after v=2**N_IN-1.
//  - Timing: each vector occupies SETTLE+1 cycles. Start accepted at edge k -> compare of vector v
//    at edge k+(v+1)*(SETTLE+1). busy falls and done/pass rise at edge k+2**N_IN*(SETTLE+1).
//  - Compare: mismatch when gut_out != TRUTH[v]; X/Z on gut_out counts as mismatch (case inequality).
//    On mismatch err_cnt increments, holding at all-ones.
//    First mismatch only: fail_valid=1 and fail_vec=v; later mismatches leave fail_vec unchanged.
//  - gut_out is ignored outside CHECK.
//  - gut_in returns to 0 on entering DONE.
//  - pass is registered, valid only with done; it is 0 whenever done=0.
//  - v counter is N_IN+1 bits internally; no wrap occurs before DONE.
//  - Reset mid-sweep aborts immediately; the next start begins at vector 0.
// TESTING (N_IN=2, SETTLE=2, TRUTH=4'b1000 unless noted)
//  1. GUT = ideal AND2 -> gut_in sequence 0,1,2,3 every 3 cycles; done/pass=1 at start-edge+12;
//     err_cnt=0, fail_valid=0.
//  2. GUT stuck-at-1 -> done=1, pass=0, err_cnt=3, fail_valid=1, fail_vec=0.
//  3. GUT = OR2 against AND truth -> err_cnt=2, fail_vec=1. Repeat with TRUTH=4'b1110 -> pass=1.
//  4. start pulsed at cycles 0 and 5 -> single sweep; done at 12 only. start again in DONE ->
//     done drops next edge, err_cnt cleared, new sweep.
//  5. rst asserted mid-sweep at cycle 7, asynchronously between edges -> all outputs 0 immediately.
//     Restart -> full 12-cycle sweep, correct result.
//  6. ERR_W=1, GUT stuck-at-0 against TRUTH=4'b1111 -> err_cnt saturates at 1, fail_vec=0, pass=0.

Source files
------------

// File: rtl/gate_truth_checker.sv
// Stimulus/response engine that sweeps every input vector of a combinational
// gate, compares each response against a truth table, and reports the outcome.
module gate_truth_checker #(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
  parameter int                 SETTLE = 2,
  parameter int                 ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N_IN-1:0]   gut_in,
  input  logic              gut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec
);

  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [N_IN:0]    V_LAST   = (N_IN + 1)'(2**N_IN - 1);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  state_t              state, state_n;
  logic [N_IN:0]       vec, vec_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                busy_n, done_n, pass_n, fail_valid_n;
  logic [ERR_W-1:0]    err_n;
  logic [N_IN-1:0]     fail_vec_n;
  logic                miss;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // Case inequality so an undriven or X response is never mistaken for a match.
  assign miss   = (gut_out !== TRUTH[vec[N_IN-1:0]]);
  assign gut_in = vec[N_IN-1:0];

  always_comb begin
    state_n      = state;
    vec_n        = vec;
    cnt_n        = cnt;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_n        = err_cnt;
    fail_valid_n = fail_valid;
    fail_vec_n   = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = HOLD;
          vec_n        = '0;
          cnt_n        = '0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_n        = '0;
          fail_valid_n = 1'b0;
          fail_vec_n   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_LAST) state_n = CHECK;
        else                 cnt_n   = cnt + 1'b1;
      end
      CHECK: begin
        if (miss) begin
          err_n = sat_inc(err_cnt);
          if (!fail_valid) begin
            fail_valid_n = 1'b1;
            fail_vec_n   = vec[N_IN-1:0];
          end
        end
        cnt_n = '0;
        // pass is judged on the count that includes this final comparison.
        if (vec == V_LAST) begin
          state_n = DONE;
          vec_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n = HOLD;
          vec_n   = vec + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_cnt    <= err_n;
      fail_valid <= fail_valid_n;
      fail_vec   <= fail_vec_n;
    end
  end

endmodule
